dp_chunk_accumulator: RTL and testbench
=======================================

// Module: dp_chunk_accumulator
// PURPOSE
// - Downstream consumer of DP_MUX: takes one NUM_MULTS-wide chunk of 16-bit features per beat,
//   plus the matching weight chunk, multiplies lane-wise and accumulates across QUART beats.
// - After the last chunk of a vector, presents the full signed dot product on a valid/ready output.
// - Drives the DP_MUX chunk select so the upstream mux is always presenting the half it expects next.
// PARAMETERS
// - MAX_FEATURES  8   features per vector; must equal QUART*NUM_MULTS.
// - NUM_MULTS     4   parallel 16x16 signed multipliers (lanes per beat).
// - QUART         MAX_FEATURES/NUM_MULTS   beats per vector; >=2.
// - ACC_W         32+$clog2(MAX_FEATURES)  result width (35 at defaults).
// PORTS
// - clk        in   1              single clock, rising edge.
// - rst        in   1              synchronous, active-high reset.
// - in_valid   in   1              chunk beat valid.
// - in_ready   out  1              block accepts a beat when in_valid&&in_ready.
// - in_feat    in   16*NUM_MULTS   feature chunk (from DP_MUX out), lane i = [16i+15:16i], signed.
// - in_wt      in   16*NUM_MULTS   weight chunk, same lane order, signed.
// - mux_sel    out  1              DP_MUX select: 1 = low half [63:0] (beat 0), 0 = high half (beat 1).
// - out_valid  out  1              result valid; held until out_ready.
// - out_ready  in   1              downstream accepts result.
// - out_sum    out  ACC_W          signed dot product, two's complement, no saturation.
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. clk and rst are the only clock/reset ports.
// - Reset: state=COLLECT, beat_cnt=0, pipeline valids=0, acc=0, in_ready=1, out_valid=0,
//   out_sum=0, mux_sel=1.
// - FSM COLLECT: in_ready=1. Each accepted beat increments beat_cnt. On the accepted beat with
//   beat_cnt==QUART-1, beat_cnt wraps to 0 and the state goes to DRAIN. Gaps (in_valid=0) allowed;
//   nothing advances in a gap.
// - mux_sel = (beat_cnt==0); combinational from the registered beat_cnt; stays 1 outside COLLECT.
// - Pipe stage 1 (registered): NUM_MULTS signed 16x16 -> 32-bit products, tagged v1, first1, last1.
// - Pipe stage 2 (registered): sign-extend products to ACC_W, sum all lanes.
//   acc <= first1 ? lane_sum : acc + lane_sum. last1 marks the final chunk.
// - DRAIN: in_ready=0; when stage 2 retires the last-tagged beat, out_sum<=acc result,
//   out_valid<=1, state->HOLD. Latency: out_valid rises 2 cycles after the last beat is accepted.
// - HOLD: in_ready=0; out_valid and out_sum stable until out_valid&&out_ready. On that cycle
//   out_valid<=0, state->COLLECT, in_ready=1 the following cycle (no same-cycle bypass).
// - Width: max |sum| = MAX_FEATURES*2^30 fits in ACC_W signed; no overflow possible by construction.
// - rst asserted in any state, including mid-vector or in HOLD: partial sums and pipeline tags are
//   discarded; all outputs return to reset values on the next edge.
// - in_feat/in_wt are ignored when not accepted; X on them while in_valid=0 must not propagate.
// STRUCTURE
// - Shared package dp_pkg: DATA_W=16, PROD_W=32, acc_w(max_features) function,
//   state enum {COLLECT, DRAIN, HOLD}.
// - One sub-module: dp_mult_row (NUM_MULTS registered signed multipliers, valid passthrough).
//   FSM, beat counter, adder tree and accumulator stay in this file.
// TESTING
// - Reset: hold rst 3 cycles -> in_ready=1, out_valid=0, out_sum=0, mux_sel=1.
// - feat 1..8 (lanes 1,2,3,4 then 5,6,7,8), wt all 1, back-to-back beats -> out_sum=36,
//   out_valid 2 cycles after beat 1; mux_sel 1 then 0.
// - Extremes: feat all 0x8000, wt all 0x8000 -> out_sum=8589934592; feat 0x7FFF, wt 0x8000
//   -> out_sum=-8589672448.
// - Backpressure: out_ready=0 for 5 cycles -> out_valid/out_sum stable, in_ready=0; a new vector
//   offered meanwhile is not accepted until the cycle after the handshake.
// - Gaps: 3 idle cycles between beat 0 and beat 1 -> same result as back-to-back, mux_sel held 0
//   through the gap.
// - rst pulsed after beat 0 of vector A, then full vector B (wt 2, feat all 1) -> out_sum=16,
//   no contribution from A.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the chunked dot-product accumulator.
//   DATA_W / PROD_W : operand and product widths of one multiplier lane.
//   acc_w()         : result width wide enough for a full vector of extreme products.
//   state_t         : accumulator FSM states.
//   beat_tag_t      : control tag that travels alongside a chunk through the pipe.
package dp_pkg;

   localparam int DATA_W = 16;
   localparam int PROD_W = 32;

   // Every product magnitude is at most 2^30, so MAX_FEATURES of them need
   // $clog2(MAX_FEATURES) extra bits above the product width.
   function automatic int acc_w(input int max_features);
      return PROD_W + $clog2(max_features);
   endfunction

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DRAIN   = 2'd1,
      HOLD    = 2'd2
   } state_t;

   typedef struct packed {
      logic vld;    // beat carries real data
      logic first;  // first chunk of a vector: restart the accumulator
      logic last;   // final chunk of a vector: result is complete after it
   } beat_tag_t;

endpackage

// File: rtl/dp_mult_row.sv
// One row of NUM_MULTS registered signed 16x16 multipliers.
//   clk, rst    : clock, synchronous active-high reset.
//   in_tag      : control tag for the beat presented this cycle.
//   feat, wt    : lane-packed signed operands.
//   out_tag     : in_tag delayed one cycle (valid passthrough).
//   prod        : lane-packed signed 32-bit products, one cycle after the operands.
module dp_mult_row
   import dp_pkg::*;
#(
   parameter int NUM_MULTS = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  beat_tag_t                             in_tag,
   input  logic      [NUM_MULTS-1:0][DATA_W-1:0] feat,
   input  logic      [NUM_MULTS-1:0][DATA_W-1:0] wt,
   output beat_tag_t                             out_tag,
   output logic      [NUM_MULTS-1:0][PROD_W-1:0] prod
);

   always_ff @(posedge clk) begin
      if (rst) out_tag <= '0;
      else     out_tag <= in_tag;
   end

   for (genvar i = 0; i < NUM_MULTS; i++) begin : g_lane
      // Operands are only captured on an accepted beat, so garbage on the
      // inputs during idle cycles never reaches the product registers.
      always_ff @(posedge clk) begin
         if (rst)
            prod[i] <= '0;
         else if (in_tag.vld)
            prod[i] <= PROD_W'($signed(feat[i])) * PROD_W'($signed(wt[i]));
      end
   end

endmodule

// File: rtl/dp_chunk_accumulator.sv
// Chunked dot-product accumulator fed by the DP_MUX.
// Takes QUART beats of NUM_MULTS feature/weight lanes, multiplies lane-wise,
// accumulates, and presents the signed dot product on a valid/ready output.
//   clk, rst             : clock, synchronous active-high reset.
//   in_valid / in_ready  : chunk beat handshake.
//   in_feat, in_wt       : lane i at [16i+15:16i], signed.
//   mux_sel              : 1 while the next beat expected is beat 0 (low half).
//   out_valid / out_ready: result handshake; result held until accepted.
//   out_sum              : signed dot product, ACC_W bits.
module dp_chunk_accumulator
   import dp_pkg::*;
#(
   parameter int MAX_FEATURES = 8,
   parameter int NUM_MULTS    = 4,
   parameter int QUART        = MAX_FEATURES / NUM_MULTS,
   parameter int ACC_W        = acc_w(MAX_FEATURES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W*NUM_MULTS-1:0] in_feat,
   input  logic [DATA_W*NUM_MULTS-1:0] in_wt,
   output logic                        mux_sel,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ACC_W-1:0]            out_sum
);

   localparam int CNT_W = (QUART > 1) ? $clog2(QUART) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(QUART - 1);

   state_t                             state;
   logic      [CNT_W-1:0]              beat_cnt;
   logic                               accept;
   beat_tag_t                          tag0;
   beat_tag_t                          tag1;
   logic      [NUM_MULTS-1:0][DATA_W-1:0] feat_lanes;
   logic      [NUM_MULTS-1:0][DATA_W-1:0] wt_lanes;
   logic      [NUM_MULTS-1:0][PROD_W-1:0] prod;
   logic      [ACC_W-1:0]              lane_sum;
   logic      [ACC_W-1:0]              acc;
   logic                               last2;

   assign in_ready   = (state == COLLECT);
   assign accept     = in_valid && in_ready;
   // beat_cnt sits at 0 outside COLLECT, so the mux idles on the low half.
   assign mux_sel    = (beat_cnt == '0);
   assign feat_lanes = in_feat;
   assign wt_lanes   = in_wt;

   assign tag0.vld   = accept;
   assign tag0.first = accept && (beat_cnt == '0);
   assign tag0.last  = accept && (beat_cnt == LAST_BEAT);

   dp_mult_row #(
      .NUM_MULTS(NUM_MULTS)
   ) u_mult_row (
      .clk    (clk),
      .rst    (rst),
      .in_tag (tag0),
      .feat   (feat_lanes),
      .wt     (wt_lanes),
      .out_tag(tag1),
      .prod   (prod)
   );

   // Sign-extend each product to the result width before summing lanes.
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < NUM_MULTS; i++)
         lane_sum = lane_sum + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
   end

   // Stage 2: accumulate. A first-tagged beat restarts the sum, so no
   // separate clear is needed between vectors.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         last2 <= 1'b0;
      end else begin
         if (tag1.vld)
            acc <= tag1.first ? lane_sum : acc + lane_sum;
         last2 <= tag1.vld && tag1.last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     state    <= DRAIN;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            DRAIN: begin
               // last2 is high the cycle after acc absorbed the final chunk.
               if (last2) begin
                  out_sum   <= acc;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_dp_chunk_accumulator.sv
// Directed bench for dp_chunk_accumulator: stimulus pushes hand-computed
// dot products into a queue; a monitor pops and compares on each handshake.
module tb_dp_chunk_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_feat;
   logic [63:0] in_wt;
   logic        mux_sel;
   logic        out_valid;
   logic        out_ready;
   logic [34:0] out_sum;

   logic signed [34:0] sum_s;
   assign sum_s = out_sum;

   int     total = 0;
   int     bad   = 0;
   longint exp_q[$];
   longint held;

   dp_chunk_accumulator dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_feat  (in_feat),
      .in_wt    (in_wt),
      .mux_sel  (mux_sel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   // Monitor: one pop per result handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL result: got %0d with no expected value queued", longint'(sum_s));
         end else begin
            chk("result", longint'(sum_s), exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a beat (called just after a rising edge) and hold it until accepted.
   task automatic send_beat(input logic [63:0] f, input logic [63:0] w);
      int n = 0;
      in_valid = 1'b1;
      in_feat  = f;
      in_wt    = w;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n == 50) chk("accept_timeout", 0, 1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [63:0] f0, input logic [63:0] f1,
                           input logic [63:0] w0, input logic [63:0] w1,
                           input longint exp);
      exp_q.push_back(exp);
      send_beat(f0, w0);
      send_beat(f1, w1);
   endtask

   // Wait (bounded) until the result handshake completes.
   task automatic wait_done();
      int n = 0;
      out_ready = 1'b1;
      @(negedge clk);
      while (!out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (n == 30) chk("result_timeout", 0, 1);
      step();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_feat   = '0;
      in_wt     = '0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", longint'(sum_s), 0);
      chk("rst_mux_sel", mux_sel, 1);
      step();
      rst = 1'b0;
      out_ready = 1'b1;

      // Basic vector with exact latency: 1+2+...+8 = 36.
      chk("mux_sel_beat0", mux_sel, 1);
      exp_q.push_back(36);
      send_beat(pk(1, 2, 3, 4), pk(1, 1, 1, 1));
      chk("mux_sel_beat1", mux_sel, 0);
      in_valid = 1'b1;
      in_feat  = pk(5, 6, 7, 8);
      in_wt    = pk(1, 1, 1, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_c0_out_valid", out_valid, 0);
      chk("drain_in_ready", in_ready, 0);
      chk("drain_mux_sel", mux_sel, 1);
      step();
      @(negedge clk);
      chk("lat_c1_out_valid", out_valid, 0);
      step();
      @(negedge clk);
      chk("lat_c2_out_valid", out_valid, 1);
      step();
      @(negedge clk);
      chk("post_hs_out_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
      step();

      // Extremes: 8 * 2^30 and 8 * (32767 * -32768).
      send_vec(64'h8000800080008000, 64'h8000800080008000,
               64'h8000800080008000, 64'h8000800080008000, 64'sd8589934592);
      wait_done();
      send_vec(64'h7FFF7FFF7FFF7FFF, 64'h7FFF7FFF7FFF7FFF,
               64'h8000800080008000, 64'h8000800080008000, -64'sd8589672448);
      wait_done();

      // Mixed signs: (-1+2-3+4-5+6-7+8) * 3 = 12.
      send_vec(pk(-1, 2, -3, 4), pk(-5, 6, -7, 8), pk(3, 3, 3, 3), pk(3, 3, 3, 3), 12);
      wait_done();

      // Backpressure: 8 * 3 = 24 held while a new vector waits.
      out_ready = 1'b0;
      send_vec(pk(1, 1, 1, 1), pk(1, 1, 1, 1), pk(3, 3, 3, 3), pk(3, 3, 3, 3), 24);
      begin
         int n = 0;
         @(negedge clk);
         while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
         end
         if (n == 30) chk("bp_timeout", 0, 1);
      end
      held = longint'(sum_s);
      chk("bp_held_value", held, 24);
      step();
      in_valid = 1'b1;
      in_feat  = pk(1, 1, 1, 1);
      in_wt    = pk(1, 1, 1, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_sum", longint'(sum_s), held);
         chk("bp_in_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("hs_cycle_in_ready", in_ready, 0);
      step();
      chk("after_hs_in_ready", in_ready, 1);
      chk("after_hs_out_valid", out_valid, 0);
      chk("after_hs_mux_sel", mux_sel, 1);
      exp_q.push_back(8);
      send_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
      send_beat(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
      wait_done();

      // Gap of 3 idle cycles between beats.
      exp_q.push_back(36);
      send_beat(pk(1, 2, 3, 4), pk(1, 1, 1, 1));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("gap_mux_sel", mux_sel, 0);
         chk("gap_in_ready", in_ready, 1);
         step();
      end
      send_beat(pk(5, 6, 7, 8), pk(1, 1, 1, 1));
      wait_done();

      // Reset mid-vector: A's first chunk must not leak into B (8 * 2 = 16).
      send_beat(pk(7, 7, 7, 7), pk(5, 5, 5, 5));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_mux_sel", mux_sel, 1);
      chk("midrst_out_valid", out_valid, 0);
      send_vec(pk(1, 1, 1, 1), pk(1, 1, 1, 1), pk(2, 2, 2, 2), pk(2, 2, 2, 2), 16);
      wait_done();

      repeat (3) step();
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
